ctl_sched: RTL
==============

Name: ctl_sched

Overview:
- Parametrised successor to the pipeline power controller.
- Gates two domains separately:
  - mic_en_o enables the PDM microphone clock.
  - en_o enables the inference pipeline.
- Adds, as new behaviour:
  - VAD debounce.
  - Microphone warm-up before the pipeline turns on.
  - Max-on watchdog.
  - Force-on bypass.
  - Saturating wake-event counter.
- Sits between the VAD detector and the pipeline/PDM clock gates.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive vad_i-high cycles required to start (>=1).
- WARMUP_CYCLES, 8: cycles with mic_en_o=1, en_o=0 before pipeline enable (>=1).
- ON_MAX_CYCLES, 1000: watchdog limit for time spent in ON (>=1).
- COOLDOWN_CYCLES, 5: cycles spent fully off after ON before VAD is re-armed (>=1).
- WAKE_CNT_BW, 8: width of the wake event counter.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- vad_i, input, 1: voice activity level.
- wake_valid_i, input, 1: inference result valid. Level; the falling edge means inference is done.
- wake_i, input, 1: inference result (1 = wake word), qualified by wake_valid_i.
- force_on_i, input, 1: hold pipeline on (debug/always-listen mode).
- wake_cnt_clr_i, input, 1: synchronous clear of wake_count_o.
- mic_en_o, output, 1: PDM mic clock enable.
- en_o, output, 1: pipeline enable.
- watchdog_o, output, 1: one-cycle pulse when the ON watchdog expires.
- state_o, output, 3: current state encoding, for debug.
- wake_count_o, output, WAKE_CNT_BW: saturating count of wake detections.

Behaviour:
- Reset (async assert, deassert on the next clk_i edge) sets:
  - state IDLE, counter 0.
  - wake_valid_q 0, wake_count_o 0, watchdog_o 0.
  - mic_en_o 0, en_o 0.
- Counter width: $clog2(max(all cycle params)+1). The counter is reset to 0 on every state transition.
- Edge detection:
  - wake_valid_q is wake_valid_i registered.
  - fe = wake_valid_q & ~wake_valid_i.
  - re = ~wake_valid_q & wake_valid_i.
- State encoding: IDLE=0, DEBOUNCE=1, WARMUP=2, ON=3, COOLDOWN=4. Any other value goes to IDLE.
- IDLE:
  - If force_on_i, go to WARMUP (debounce skipped).
  - Else if vad_i and DEBOUNCE_CYCLES==1, go to WARMUP.
  - Else if vad_i, go to DEBOUNCE with counter<=1.
- DEBOUNCE:
  - If !vad_i, go to IDLE.
  - Else if counter==DEBOUNCE_CYCLES-1, go to WARMUP.
  - Else counter+1.
- WARMUP:
  - mic_en_o=1, en_o=0.
  - When counter==WARMUP_CYCLES-1, go to ON; else counter+1.
  - vad_i is ignored.
- ON:
  - mic_en_o=1, en_o=1.
  - If force_on_i: stay in ON, counter held 0, fe ignored.
  - Else if fe, go to COOLDOWN.
  - Else if counter==ON_MAX_CYCLES-1, go to COOLDOWN and register watchdog_o=1 for exactly one cycle, coincident with the first COOLDOWN cycle.
  - Else counter+1.
  - If fe and watchdog expiry coincide, fe wins and there is no watchdog pulse.
- COOLDOWN:
  - Both enables 0.
  - When counter==COOLDOWN_CYCLES-1, go to IDLE; else counter+1.
  - vad_i and force_on_i are ignored until IDLE is reached.
- Outputs: mic_en_o, en_o and state_o are decoded from the registered state, with no combinational path from inputs. en_o rises exactly WARMUP_CYCLES cycles after mic_en_o rises.
- Wake counter:
  - Increments on re & wake_i only while in state ON.
  - Saturates at 2^WAKE_CNT_BW-1.
  - wake_cnt_clr_i has priority over an increment in the same cycle.
- force_on_i deasserted while in ON: the normal fe/watchdog rules resume, with the counter starting from 0.
- Reset asserted mid-operation: enables drop immediately (async). No pulse on any output.

Test Plan:
- Debounce accept:
  - Stimulus: vad_i high 4 cycles from IDLE.
  - Response: state DEBOUNCE→WARMUP; mic_en_o=1 on cycle 5; en_o=1 8 cycles later.
- Debounce reject:
  - Stimulus: vad_i high 3 cycles, low 1, high 3.
  - Response: returns to IDLE; mic_en_o stays 0 throughout.
- Normal inference:
  - Stimulus: in ON, wake_valid_i high 2 cycles with wake_i=1, then low.
  - Response: wake_count_o 0→1 one cycle after the rise; en_o and mic_en_o drop one cycle after the fall; IDLE after 5 COOLDOWN cycles; vad_i ignored during COOLDOWN.
- Watchdog:
  - Stimulus: ON with no wake_valid_i activity.
  - Response: after 1000 cycles, watchdog_o pulses 1 cycle and en_o=0.
  - Stimulus: fe on the expiry cycle.
  - Response: no watchdog_o pulse.
- Force-on and counter:
  - Stimulus: force_on_i=1 from IDLE; then 300 wake events with WAKE_CNT_BW=8.
  - Response: WARMUP→ON without debounce; stays ON past 1000 cycles; wake_count_o saturates at 255.
  - Stimulus: clr asserted coincident with a wake event.
  - Response: wake_count_o reads 0.
- Async reset:
  - Stimulus: assert rst_i mid-WARMUP between clock edges.
  - Response: mic_en_o=0 and state_o=0 before the next edge; wake_count_o=0.

Source files
------------

// File: rtl/ctl_sched.sv
// Power scheduler for the wake-word path: debounces VAD, warms the PDM mic up
// before enabling the pipeline, and bounds the time spent on with a watchdog.
module ctl_sched #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WARMUP_CYCLES   = 8,
  parameter int ON_MAX_CYCLES   = 1000,
  parameter int COOLDOWN_CYCLES = 5,
  parameter int WAKE_CNT_BW     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   vad_i,
  input  logic                   wake_valid_i,
  input  logic                   wake_i,
  input  logic                   force_on_i,
  input  logic                   wake_cnt_clr_i,
  output logic                   mic_en_o,
  output logic                   en_o,
  output logic                   watchdog_o,
  output logic [2:0]             state_o,
  output logic [WAKE_CNT_BW-1:0] wake_count_o
);

  localparam int MAX_A  = (DEBOUNCE_CYCLES > WARMUP_CYCLES) ? DEBOUNCE_CYCLES : WARMUP_CYCLES;
  localparam int MAX_B  = (ON_MAX_CYCLES > COOLDOWN_CYCLES) ? ON_MAX_CYCLES : COOLDOWN_CYCLES;
  localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WU_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(ON_MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    WARMUP   = 3'd2,
    ON       = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   wake_valid_q;
  logic [WAKE_CNT_BW-1:0] wake_count;
  logic                   watchdog;
  logic                   fe;
  logic                   re;

  function automatic logic [WAKE_CNT_BW-1:0] sat_inc(input logic [WAKE_CNT_BW-1:0] v);
    return (v == {WAKE_CNT_BW{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign fe = wake_valid_q & ~wake_valid_i;
  assign re = ~wake_valid_q & wake_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      wake_valid_q <= 1'b0;
      wake_count   <= '0;
      watchdog     <= 1'b0;
    end else begin
      wake_valid_q <= wake_valid_i;
      watchdog     <= 1'b0;

      // Clear outranks a same-cycle wake detection.
      if (wake_cnt_clr_i)
        wake_count <= '0;
      else if (state == ON && re && wake_i)
        wake_count <= sat_inc(wake_count);

      case (state)
        IDLE: begin
          if (force_on_i || (vad_i && DEBOUNCE_CYCLES == 1)) begin
            state <= WARMUP;
            cnt   <= '0;
          end else if (vad_i) begin
            state <= DEBOUNCE;
            cnt   <= CNT_ONE;
          end
        end
        DEBOUNCE: begin
          if (!vad_i) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= WARMUP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WARMUP: begin
          if (cnt == WU_LAST) begin
            state <= ON;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ON: begin
          // An inference-done edge beats a coincident watchdog expiry.
          if (force_on_i) begin
            cnt <= '0;
          end else if (fe) begin
            state <= COOLDOWN;
            cnt   <= '0;
          end else if (cnt == ON_LAST) begin
            state    <= COOLDOWN;
            cnt      <= '0;
            watchdog <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COOLDOWN: begin
          if (cnt == CD_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Enables decode the state register only, so reset drops them asynchronously.
  assign mic_en_o     = (state == WARMUP) || (state == ON);
  assign en_o         = (state == ON);
  assign watchdog_o   = watchdog;
  assign state_o      = state;
  assign wake_count_o = wake_count;

endmodule
